// File: rtl/ebr_bank_buffer_pkg.sv
// Shared definitions for the multi-bank EBR buffer: width helpers and the
// bank-pointer increment used by both the fill and drain sides.
package ebr_bank_buffer_pkg;

  localparam int PTR_MAX_W = 4;

  typedef logic [PTR_MAX_W-1:0] bank_ptr_t;

  function automatic int bank_bits(input int num_banks);
    return (num_banks <= 2) ? 1 : $clog2(num_banks);
  endfunction

  function automatic int count_bits(input int num_banks);
    return $clog2(num_banks + 1);
  endfunction

  function automatic int ram_aw(input int addr_width, input int num_banks);
    return $clog2(num_banks * (2 ** addr_width));
  endfunction

  function automatic bit is_pow2(input int n);
    return (n & (n - 1)) == 0;
  endfunction

  // Explicit wrap so non-power-of-two bank counts never reach an unused index.
  function automatic bank_ptr_t bank_next(input bank_ptr_t cur, input int num_banks);
    if (int'(cur) == num_banks - 1) return '0;
    return cur + bank_ptr_t'(1);
  endfunction

endpackage

// File: rtl/ebr_bank_buffer_sdp_ram.sv
// Single-clock simple dual-port RAM with registered, enabled read; shaped so
// the iCE40 flow maps it onto EBR.
module sdp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ebr_bank_buffer.sv
// N-bank block-RAM buffer: producer fills and commits banks, consumer reads
// committed banks and releases them; ownership is tracked by two pointers and a count.
module ebr_bank_buffer
  import ebr_bank_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BANKS  = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           wr_commit,
  output logic                           wr_ready,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_data_valid,
  input  logic                           rd_release,
  output logic                           rd_valid,
  output logic [$clog2(NUM_BANKS+1)-1:0] full_count,
  output logic                           error
);

  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int BANK_BITS  = bank_bits(NUM_BANKS);
  localparam int COUNT_BITS = count_bits(NUM_BANKS);
  localparam int RAM_AW     = ram_aw(ADDR_WIDTH, NUM_BANKS);
  localparam int RAM_DEPTH  = NUM_BANKS * DEPTH;

  logic [BANK_BITS-1:0]  wr_bank_q, wr_bank_d;
  logic [BANK_BITS-1:0]  rd_bank_q, rd_bank_d;
  logic [COUNT_BITS-1:0] full_count_q, full_count_d;
  logic                  error_q, error_d;
  logic                  rd_data_valid_q, rd_data_valid_d;
  logic                  rd_seen_q, rd_seen_d;

  logic wr_acc, commit_acc, rd_acc, rel_acc;
  logic [RAM_AW-1:0]     wr_phys, rd_phys;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_ready = (full_count_q != COUNT_BITS'(NUM_BANKS));
  assign rd_valid = (full_count_q != '0);

  assign wr_acc     = wr_en & wr_ready;
  assign commit_acc = wr_commit & wr_ready;
  assign rd_acc     = rd_en & rd_valid;
  assign rel_acc    = rd_release & rd_valid;

  generate
    if (is_pow2(NUM_BANKS)) begin : g_concat_addr
      assign wr_phys = {wr_bank_q, wr_addr};
      assign rd_phys = {rd_bank_q, rd_addr};
    end else begin : g_mult_addr
      assign wr_phys = RAM_AW'(wr_bank_q) * RAM_AW'(DEPTH) + RAM_AW'(wr_addr);
      assign rd_phys = RAM_AW'(rd_bank_q) * RAM_AW'(DEPTH) + RAM_AW'(rd_addr);
    end
  endgenerate

  sdp_ram #(
    .DATA_W (DATA_WIDTH),
    .ADDR_W (RAM_AW),
    .DEPTH  (RAM_DEPTH)
  ) u_ram (
    .clk   (clock),
    .we    (wr_acc),
    .waddr (wr_phys),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_phys),
    .rdata (ram_rdata)
  );

  always_comb begin
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    full_count_d    = full_count_q;
    rd_data_valid_d = rd_acc;
    rd_seen_d       = rd_seen_q | rd_acc;
    error_d         = error_q
                    | (wr_en      & ~wr_ready)
                    | (wr_commit  & ~wr_ready)
                    | (rd_en      & ~rd_valid)
                    | (rd_release & ~rd_valid);

    if (commit_acc) wr_bank_d = BANK_BITS'(bank_next(bank_ptr_t'(wr_bank_q), NUM_BANKS));
    if (rel_acc)    rd_bank_d = BANK_BITS'(bank_next(bank_ptr_t'(rd_bank_q), NUM_BANKS));

    unique case ({commit_acc, rel_acc})
      2'b10:   full_count_d = full_count_q + COUNT_BITS'(1);
      2'b01:   full_count_d = full_count_q - COUNT_BITS'(1);
      default: full_count_d = full_count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_bank_q       <= '0;
      rd_bank_q       <= '0;
      full_count_q    <= '0;
      error_q         <= 1'b0;
      rd_data_valid_q <= 1'b0;
      rd_seen_q       <= 1'b0;
    end else begin
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      full_count_q    <= full_count_d;
      error_q         <= error_d;
      rd_data_valid_q <= rd_data_valid_d;
      rd_seen_q       <= rd_seen_d;
    end
  end

  // EBR output register has no reset; present zero until the first read lands.
  assign rd_data       = rd_seen_q ? ram_rdata : '0;
  assign rd_data_valid = rd_data_valid_q;
  assign full_count    = full_count_q;
  assign error         = error_q;

endmodule

// File: tb/tb_ebr_bank_buffer.sv
// Bench for ebr_bank_buffer: instance 0 has two banks, instance 1 has three.
module tb_ebr_bank_buffer;

  localparam int AW = 6;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          wr_en         [2];
  logic [AW-1:0] wr_addr       [2];
  logic [DW-1:0] wr_data       [2];
  logic          wr_commit     [2];
  logic          wr_ready      [2];
  logic          rd_en         [2];
  logic [AW-1:0] rd_addr       [2];
  logic [DW-1:0] rd_data       [2];
  logic          rd_data_valid [2];
  logic          rd_release    [2];
  logic          rd_valid      [2];
  logic [1:0]    full_count    [2];
  logic          error         [2];

  ebr_bank_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(2)) dut2 (
    .clock(clock), .reset(reset),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .wr_commit(wr_commit[0]), .wr_ready(wr_ready[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .rd_data_valid(rd_data_valid[0]), .rd_release(rd_release[0]),
    .rd_valid(rd_valid[0]), .full_count(full_count[0]), .error(error[0])
  );

  ebr_bank_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(3)) dut3 (
    .clock(clock), .reset(reset),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .wr_commit(wr_commit[1]), .wr_ready(wr_ready[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .rd_data_valid(rd_data_valid[1]), .rd_release(rd_release[1]),
    .rd_valid(rd_valid[1]), .full_count(full_count[1]), .error(error[1])
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sbq0[$];
  logic [DW-1:0] sbq1[$];

  typedef struct {
    bit          wr;
    bit [AW-1:0] waddr;
    bit [DW-1:0] wdata;
    bit          commit;
    bit          rd;
    bit [AW-1:0] raddr;
    bit [DW-1:0] rexp;
    bit          rel;
    int          cnt;
    bit          wrdy;
    bit          rvld;
  } vec_t;

  vec_t tbl[$];
  vec_t v;
  int   mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear();
    for (int i = 0; i < 2; i++) begin
      wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0; wr_commit[i] = 1'b0;
      rd_en[i] = 1'b0; rd_addr[i] = '0; rd_release[i] = 1'b0;
    end
  endtask

  task automatic monitor();
    logic [DW-1:0] e;
    if (rd_data_valid[0]) begin
      if (sbq0.size() == 0) chk("dut2 spurious rd_data_valid", 1, 0);
      else begin e = sbq0.pop_front(); chk("dut2 rd_data", 32'(rd_data[0]), 32'(e)); end
    end else if (sbq0.size() != 0) begin
      chk("dut2 rd_data_valid late", 0, 1);
      void'(sbq0.pop_front());
    end
    if (rd_data_valid[1]) begin
      if (sbq1.size() == 0) chk("dut3 spurious rd_data_valid", 1, 0);
      else begin e = sbq1.pop_front(); chk("dut3 rd_data", 32'(rd_data[1]), 32'(e)); end
    end else if (sbq1.size() != 0) begin
      chk("dut3 rd_data_valid late", 0, 1);
      void'(sbq1.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    monitor();
    clear();
  endtask

  task automatic wr(input int i, input int a, input int d);
    wr_en[i] = 1'b1; wr_addr[i] = AW'(a); wr_data[i] = DW'(d);
  endtask

  task automatic rd(input int i, input int a, input logic [DW-1:0] exp);
    rd_en[i] = 1'b1; rd_addr[i] = AW'(a);
    if (i == 0) sbq0.push_back(exp); else sbq1.push_back(exp);
  endtask

  task automatic st(input int i, input string tag, input int cnt, input bit wrdy,
                    input bit rvld, input bit err);
    chk($sformatf("%s full_count", tag), 32'(full_count[i]), 32'(cnt));
    chk($sformatf("%s wr_ready", tag),   32'(wr_ready[i]),   32'(wrdy));
    chk($sformatf("%s rd_valid", tag),   32'(rd_valid[i]),   32'(rvld));
    chk($sformatf("%s error", tag),      32'(error[i]),      32'(err));
  endtask

  function automatic logic [DW-1:0] dval(input int k, input bit hi);
    logic [3:0] b;
    logic [3:0] lo;
    b  = 4'(k % 3);
    lo = hi ? 4'(k + 8) : 4'(k);
    return {b, lo};
  endfunction

  task automatic add_fill(input int k);
    vec_t e;
    e = '{default: 0};
    e.wr = 1; e.waddr = 42; e.wdata = dval(k, 1);
    e.cnt = mcnt; e.wrdy = (mcnt != 3); e.rvld = (mcnt != 0);
    tbl.push_back(e);
    e.waddr = 21; e.wdata = dval(k, 0); e.commit = 1;
    mcnt++;
    e.cnt = mcnt; e.wrdy = (mcnt != 3); e.rvld = (mcnt != 0);
    tbl.push_back(e);
  endtask

  task automatic add_drain(input int j);
    vec_t e;
    e = '{default: 0};
    e.rd = 1; e.raddr = 42; e.rexp = dval(j, 1);
    e.cnt = mcnt; e.wrdy = (mcnt != 3); e.rvld = (mcnt != 0);
    tbl.push_back(e);
    e.raddr = 21; e.rexp = dval(j, 0); e.rel = 1;
    mcnt--;
    e.cnt = mcnt; e.wrdy = (mcnt != 3); e.rvld = (mcnt != 0);
    tbl.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear();
    reset = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      st(i, $sformatf("reset[%0d]", i), 0, 1, 0, 0);
      chk($sformatf("reset[%0d] rd_data", i), 32'(rd_data[i]), 0);
      chk($sformatf("reset[%0d] rd_data_valid", i), 32'(rd_data_valid[i]), 0);
    end
    reset = 1'b0;

    // Fill bank 0 with data = addr, commit, read back word 5.
    for (int a = 0; a < 64; a++) begin wr(0, a, a); tick(); end
    wr_commit[0] = 1'b1; tick();
    st(0, "t1 commit", 1, 1, 1, 0);
    rd(0, 5, 8'd5); tick();
    tick();
    chk("t1 rd_data hold", 32'(rd_data[0]), 5);

    // Second bank fills the two-bank buffer; writes and commits now rejected.
    for (int a = 0; a < 64; a++) begin wr(0, a, 8'h80 | a); tick(); end
    wr_commit[0] = 1'b1; tick();
    st(0, "t2 full", 2, 0, 1, 0);
    wr(0, 5, 8'hEE); tick();
    st(0, "t2 drop write", 2, 0, 1, 1);
    wr_commit[0] = 1'b1; tick();
    st(0, "t2 drop commit", 2, 0, 1, 1);
    rd(0, 5, 8'd5); tick();

    // Read with release returns the old bank; then commit+release together at count 1.
    rd(0, 10, 8'd10); rd_release[0] = 1'b1; tick();
    st(0, "t3 release", 1, 1, 1, 1);
    wr(0, 3, 8'h43); tick();
    wr(0, 10, 8'h4A); tick();
    rd(0, 7, 8'h87); tick();
    wr_commit[0] = 1'b1; rd_release[0] = 1'b1; tick();
    st(0, "t3 commit+release", 1, 1, 1, 1);
    rd(0, 3, 8'h43); tick();

    // Write alongside commit lands in the committed bank; drain to empty.
    wr(0, 3, 8'h13); wr_commit[0] = 1'b1; tick();
    st(0, "t4 commit", 2, 0, 1, 1);
    rd(0, 10, 8'h4A); rd_release[0] = 1'b1; tick();
    st(0, "t4 release", 1, 1, 1, 1);
    rd(0, 3, 8'h13); rd_release[0] = 1'b1; tick();
    st(0, "t4 empty", 0, 1, 0, 1);
    rd_en[0] = 1'b1; rd_addr[0] = 6'd3; tick();
    chk("t4 rd_data hold after rejected read", 32'(rd_data[0]), 32'h13);

    // Three-bank buffer: pointers walk 0,1,2,0,1,2,0 on both sides.
    mcnt = 0;
    add_fill(0); add_fill(1); add_fill(2);
    add_drain(0); add_fill(3);
    add_drain(1); add_fill(4);
    add_drain(2); add_fill(5);
    add_drain(3); add_fill(6);
    add_drain(4); add_drain(5); add_drain(6);
    for (int n = 0; n < tbl.size(); n++) begin
      v = tbl[n];
      if (v.wr) wr(1, int'(v.waddr), int'(v.wdata));
      wr_commit[1] = v.commit;
      if (v.rd) rd(1, int'(v.raddr), v.rexp);
      rd_release[1] = v.rel;
      tick();
      st(1, $sformatf("nb3 step %0d", n), v.cnt, v.wrdy, v.rvld, 0);
    end
    rd_en[1] = 1'b1; rd_addr[1] = 6'd21; tick();
    st(1, "nb3 read empty", 0, 1, 0, 1);
    rd_release[1] = 1'b1; tick();
    st(1, "nb3 release empty", 0, 1, 0, 1);

    // Reset in the middle of reading a full buffer discards everything.
    wr_commit[0] = 1'b1; tick();
    wr_commit[0] = 1'b1; tick();
    st(0, "t5 full", 2, 0, 1, 1);
    rd(0, 20, 8'd20); tick();
    rd_en[0] = 1'b1; rd_addr[0] = 6'd21; reset = 1'b1; tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st(i, $sformatf("t5 reset[%0d]", i), 0, 1, 0, 0);
      chk($sformatf("t5 reset[%0d] rd_data_valid", i), 32'(rd_data_valid[i]), 0);
      chk($sformatf("t5 reset[%0d] rd_data", i), 32'(rd_data[i]), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
